// File: rtl/paddle_pos_ctrl_if.sv
// Paddle control bus: frame tick and button levels in, position and flags out.
interface paddle_pos_ctrl_if;
  logic       frame_tick;
  logic       btn_up;
  logic       btn_down;
  logic [9:0] loc;
  logic       moving;
  logic       at_min;
  logic       at_max;

  modport master (
    output frame_tick, btn_up, btn_down,
    input  loc, moving, at_min, at_max
  );

  modport slave (
    input  frame_tick, btn_up, btn_down,
    output loc, moving, at_min, at_max
  );
endinterface

// File: rtl/paddle_pos_ctrl.sv
// Paddle position controller. Commits one rest/up/down step decision per
// frame_tick, with press-pause-repeat behaviour while a button is held.
// Optional feature macro: POS_WRAP_EN (wrap at the ends instead of clamping).
module paddle_pos_ctrl #(
  parameter int INIT_POS     = 240,
  parameter int MIN_POS      = 0,
  parameter int MAX_POS      = 400,
  parameter int STEP         = 1,
  parameter int REPEAT_DELAY = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  paddle_pos_ctrl_if.slave  bus
);

  localparam logic [9:0]         LOC_INIT  = 10'(INIT_POS);
  localparam logic [9:0]         LOC_MIN   = 10'(MIN_POS);
  localparam logic [9:0]         LOC_MAX   = 10'(MAX_POS);
  localparam logic signed [10:0] STEP_S    = 11'(STEP);
  localparam logic signed [10:0] MIN_S     = 11'(MIN_POS);
  localparam logic signed [10:0] MAX_S     = 11'(MAX_POS);
  localparam logic [7:0]         HOLD_LAST = 8'(REPEAT_DELAY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT
  } state_t;

  state_t     state, state_nxt;
  logic       dir_dn, dir_dn_nxt;
  logic [7:0] hold_cnt, hold_nxt;
  logic [9:0] loc_q, loc_nxt;
  logic       moving_q;
  logic       mv_up, mv_dn;
  logic       req_up, req_dn, req_any, req_same;

  // Upward step with end-of-travel handling; carry is visible in the 11-bit sum.
  function automatic logic [9:0] step_up(input logic [9:0] cur);
    logic signed [10:0] sum;
    logic signed [10:0] res;
    sum = $signed({1'b0, cur}) + STEP_S;
    res = sum;
    if (sum > MAX_S) begin
`ifdef POS_WRAP_EN
      res = MIN_S + (sum - MAX_S - 11'sd1);
`else
      res = MAX_S;
`endif
    end
    return res[9:0];
  endfunction

  // Downward step with end-of-travel handling; borrow shows as a negative difference.
  function automatic logic [9:0] step_dn(input logic [9:0] cur);
    logic signed [10:0] diff;
    logic signed [10:0] res;
    diff = $signed({1'b0, cur}) - STEP_S;
    res  = diff;
    if (diff < MIN_S) begin
`ifdef POS_WRAP_EN
      res = MAX_S - (MIN_S - diff - 11'sd1);
`else
      res = MIN_S;
`endif
    end
    return res[9:0];
  endfunction

  // Pressing both buttons counts as no request.
  assign req_up   = bus.btn_up & ~bus.btn_down;
  assign req_dn   = bus.btn_down & ~bus.btn_up;
  assign req_any  = req_up | req_dn;
  assign req_same = (req_up & ~dir_dn) | (req_dn & dir_dn);

  // Next-state and move decision; only a frame_tick cycle may change anything.
  always_comb begin
    state_nxt  = state;
    dir_dn_nxt = dir_dn;
    hold_nxt   = hold_cnt;
    mv_up      = 1'b0;
    mv_dn      = 1'b0;
    if (bus.frame_tick) begin
      case (state)
        S_IDLE: begin
          if (req_any) begin
            mv_up      = req_up;
            mv_dn      = req_dn;
            dir_dn_nxt = req_dn;
            hold_nxt   = 8'd0;
            state_nxt  = S_DELAY;
          end
        end
        S_DELAY: begin
          if (!req_any) begin
            hold_nxt  = 8'd0;
            state_nxt = S_IDLE;
          end else if (req_same) begin
            hold_nxt = hold_cnt + 8'd1;
            if (hold_cnt == HOLD_LAST) state_nxt = S_REPEAT;
          end else begin
            mv_up      = req_up;
            mv_dn      = req_dn;
            dir_dn_nxt = req_dn;
            hold_nxt   = 8'd0;
          end
        end
        S_REPEAT: begin
          if (!req_any) begin
            hold_nxt  = 8'd0;
            state_nxt = S_IDLE;
          end else if (req_same) begin
            mv_up = req_up;
            mv_dn = req_dn;
          end else begin
            mv_up      = req_up;
            mv_dn      = req_dn;
            dir_dn_nxt = req_dn;
            hold_nxt   = 8'd0;
            state_nxt  = S_DELAY;
          end
        end
        default: begin
          hold_nxt  = 8'd0;
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Next position selected from rest / up / down.
  assign loc_nxt = mv_up ? step_up(loc_q) :
                   mv_dn ? step_dn(loc_q) : loc_q;

  // State, position and moving flag registers; position and flag commit on frame_tick only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      dir_dn   <= 1'b0;
      hold_cnt <= 8'd0;
      loc_q    <= LOC_INIT;
      moving_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      dir_dn   <= dir_dn_nxt;
      hold_cnt <= hold_nxt;
      if (bus.frame_tick) begin
        loc_q    <= loc_nxt;
        moving_q <= (loc_nxt != loc_q);
      end
    end
  end

  assign bus.loc    = loc_q;
  assign bus.moving = moving_q;
  assign bus.at_min = (loc_q == LOC_MIN);
  assign bus.at_max = (loc_q == LOC_MAX);

endmodule
